// File: rtl/tb_usb_tx_pkg.sv
// Shared types and constants for the test-bench-side USB full-speed transmitter.
package tb_usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;

    // Bus symbols as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] level_to_line(input logic level_j);
        return level_j ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/tb_flex_pts_sr.sv
// Parameterised parallel-to-serial shift register; shifts in ones behind the data.
module tb_flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '1;
        end else if (load_enable) begin
            q <= parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB) q <= {q[NUM_BITS-2:0], 1'b1};
            else           q <= {1'b1, q[NUM_BITS-1:1]};
        end
    end

    assign serial_out = SHIFT_MSB ? q[NUM_BITS-1] : q[0];

endmodule

// File: rtl/tb_usb_tx_encoder.sv
// USB full-speed transmitter: SYNC + LSB-first payload with bit stuffing and NRZI, then EOP.
// Handshake: a byte transfers on any cycle where tx_valid && tx_ready; tx_data/tx_last must be stable while tx_valid is high.
module tb_usb_tx_encoder
    import tb_usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       busy,
    output logic       tx_underrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    tx_state_t       state, state_n, ret_state, ret_n;
    logic [TW-1:0]   bit_timer;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [2:0]      stuff_cnt, stuff_cnt_n;
    logic            level_j, level_n;
    logic [1:0]      line, line_n;
    logic            cur_last, cur_last_n;
    logic            underrun_n;
    logic [7:0]      hold_data;
    logic            hold_last, hold_full, last_accepted;
    logic            accept, wrap, take_hold, leave_eop;
    logic            load_en, shift_en, serial_out;
    logic [7:0]      load_val;
    logic            emit, emit_bit;

    assign accept   = tx_valid && tx_ready;
    assign tx_ready = !hold_full && !last_accepted;
    assign wrap     = (bit_timer == TW'(CLKS_PER_BIT - 1));
    assign busy     = (state != IDLE);
    assign d_plus   = line[1];
    assign d_minus  = line[0];

    // The register holds the bits still to come after the one currently on the line.
    tb_flex_pts_sr #(
        .NUM_BITS (8),
        .SHIFT_MSB(1'b0)
    ) u_sr (
        .clk         (clk),
        .n_rst       (n_rst),
        .shift_enable(shift_en),
        .load_enable (load_en),
        .parallel_in (load_val),
        .serial_out  (serial_out)
    );

    always_comb begin
        state_n     = state;
        ret_n       = ret_state;
        bit_cnt_n   = bit_cnt;
        stuff_cnt_n = stuff_cnt;
        level_n     = level_j;
        line_n      = line;
        cur_last_n  = cur_last;
        underrun_n  = 1'b0;
        load_en     = 1'b0;
        shift_en    = 1'b0;
        load_val    = '0;
        take_hold   = 1'b0;
        leave_eop   = 1'b0;
        emit        = 1'b0;
        emit_bit    = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full || accept) begin
                    state_n    = SYNC;
                    bit_cnt_n  = '0;
                    cur_last_n = 1'b0;
                    load_en    = 1'b1;
                    load_val   = SYNC_BYTE >> 1;
                    emit       = 1'b1;
                    emit_bit   = SYNC_BYTE[0];
                end
            end
            SYNC, DATA, STUFF: begin
                if (wrap) begin
                    // An owed stuff bit always goes out before the byte-boundary decision.
                    if (stuff_cnt == 3'(STUFF_LIMIT)) begin
                        state_n  = STUFF;
                        ret_n    = state;
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                    end else if (bit_cnt != 3'd7) begin
                        state_n   = (state == STUFF) ? ret_state : state;
                        shift_en  = 1'b1;
                        bit_cnt_n = bit_cnt + 3'd1;
                        emit      = 1'b1;
                        emit_bit  = serial_out;
                    end else if (hold_full) begin
                        state_n    = DATA;
                        take_hold  = 1'b1;
                        load_en    = 1'b1;
                        load_val   = hold_data >> 1;
                        bit_cnt_n  = '0;
                        cur_last_n = hold_last;
                        emit       = 1'b1;
                        emit_bit   = hold_data[0];
                    end else begin
                        state_n    = EOP_SE0;
                        bit_cnt_n  = '0;
                        line_n     = LINE_SE0;
                        underrun_n = !cur_last;
                    end
                end
            end
            EOP_SE0: begin
                if (wrap) begin
                    if (bit_cnt == 3'd1) begin
                        state_n = EOP_J;
                        line_n  = LINE_J;
                    end else begin
                        bit_cnt_n = 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (wrap) begin
                    state_n     = IDLE;
                    bit_cnt_n   = '0;
                    stuff_cnt_n = '0;
                    level_n     = 1'b1;
                    leave_eop   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it; ones are counted for stuffing.
        if (emit) begin
            level_n     = emit_bit ? level_j : !level_j;
            line_n      = level_to_line(level_n);
            stuff_cnt_n = emit_bit ? stuff_cnt + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            ret_state   <= DATA;
            bit_timer   <= '0;
            bit_cnt     <= '0;
            stuff_cnt   <= '0;
            level_j     <= 1'b1;
            line        <= LINE_J;
            cur_last    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_n;
            ret_state   <= ret_n;
            bit_cnt     <= bit_cnt_n;
            stuff_cnt   <= stuff_cnt_n;
            level_j     <= level_n;
            line        <= line_n;
            cur_last    <= cur_last_n;
            tx_underrun <= underrun_n;
            if (state == IDLE || wrap) bit_timer <= '0;
            else                       bit_timer <= bit_timer + TW'(1);
        end
    end

    // Holding register; an accept in the same cycle as a load keeps it full.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_data     <= '0;
            hold_last     <= 1'b0;
            hold_full     <= 1'b0;
            last_accepted <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end else if (take_hold) begin
                hold_full <= 1'b0;
            end
            if (accept && tx_last) last_accepted <= 1'b1;
            else if (leave_eop)    last_accepted <= 1'b0;
        end
    end

endmodule
